// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: start strobe, operands and op in; busy/done/result out.
interface muldiv_unit_if;
  logic        i_start;
  logic [31:0] i_1;
  logic [31:0] i_2;
  logic [1:0]  i_ctrl;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_1;
  logic        o_zero;

  modport master (output i_start, i_1, i_2, i_ctrl, input o_busy, o_done, o_1, o_zero);
  modport slave  (input i_start, i_1, i_2, i_ctrl, output o_busy, o_done, o_1, o_zero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU, one radix-2 step per clock.
// Optional MULDIV_ZERO_BYPASS_EN short-cuts zero-operand multiplies and divide-by-zero.
module muldiv_unit (
  input  logic         i_clk,
  input  logic         i_rst_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [31:0] opb;   // multiplicand or divisor
  logic [31:0] acc;   // product high half / partial remainder
  logic [31:0] q;     // multiplier -> product low half / dividend -> quotient
  logic        byp;

  logic [32:0] mul_sum, div_sh, div_diff;
  logic [31:0] acc_nxt, q_nxt, res_nxt, byp_res, fin_res;
  logic        byp_hit;

  always_comb begin
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, opb} : 33'd0);
    div_sh   = {acc, q[31]};
    div_diff = div_sh - {1'b0, opb};
    if (!op[1]) begin
      acc_nxt = mul_sum[32:1];
      q_nxt   = {mul_sum[0], q[31:1]};
    end else if (!div_diff[32]) begin
      acc_nxt = div_diff[31:0];
      q_nxt   = {q[30:0], 1'b1};
    end else begin
      acc_nxt = div_sh[31:0];
      q_nxt   = {q[30:0], 1'b0};
    end
    // MUL/DIVU take the low/quotient word, MULHU/REMU the high/remainder word
    res_nxt = op[0] ? acc_nxt : q_nxt;
    byp_res = !op[1] ? 32'd0 : (op[0] ? q : 32'hFFFF_FFFF);
    fin_res = byp ? byp_res : res_nxt;
  end

`ifdef MULDIV_ZERO_BYPASS_EN
  assign byp_hit = bus.i_ctrl[1] ? (bus.i_2 == 32'd0)
                                 : ((bus.i_1 == 32'd0) || (bus.i_2 == 32'd0));
`else
  assign byp_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      op         <= 2'd0;
      opb        <= 32'd0;
      acc        <= 32'd0;
      q          <= 32'd0;
      byp        <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_1    <= 32'd0;
      bus.o_zero <= 1'b1;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          op         <= bus.i_ctrl;
          opb        <= bus.i_2;
          acc        <= 32'd0;
          q          <= bus.i_1;
          byp        <= byp_hit;
          // a bypassed op spends a single cycle in RUN, landing o_done one edge after start
          cnt        <= byp_hit ? 5'd31 : 5'd0;
          state      <= RUN;
          bus.o_busy <= 1'b1;
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            bus.o_1    <= fin_res;
            bus.o_zero <= (fin_res == 32'd0);
            bus.o_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, busy window, start-ignore, reset abort.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

`ifdef MULDIV_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 32;
`endif

  muldiv_unit_if bus();
  muldiv_unit dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called #1 after a rising edge; the next edge is E0.
  task automatic run_op(input string tag, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    int busy_n, lat;
    bit seen;
    bus.i_start = 1'b1; bus.i_ctrl = c; bus.i_1 = a; bus.i_2 = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    busy_n = bus.o_busy ? 1 : 0;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin seen = 1'b1; lat = k; end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat_exp + 1));
    chk({tag, "_result"}, bus.o_1, exp);
    chk({tag, "_zero"}, 32'(bus.o_zero), 32'(exp == 32'd0));
    @(posedge clk); #1;
    chk({tag, "_done_pulse_1cyc"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_hold"}, bus.o_1, exp);
  endtask

  initial begin
    int dones;
    bit seen;
    bus.i_start = 1'b0; bus.i_ctrl = 2'd0; bus.i_1 = 32'd0; bus.i_2 = 32'd0;
    #12;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_o1", bus.o_1, 32'd0);
    chk("rst_zero", 32'(bus.o_zero), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first start lands on the first edge after reset release
    run_op("mul_7x6",      2'b00, 32'd7,          32'd6,          32'd42,         32);
    run_op("mulhu_ff",     2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32);
    run_op("mul_ff",       2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32);
    run_op("mulhu_2",      2'b01, 32'h8000_0000,  32'd4,          32'd2,          32);
    run_op("divu_100_7",   2'b10, 32'd100,        32'd7,          32'd14,         32);
    run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          32);
    run_op("remu_12_4",    2'b11, 32'd12,         32'd4,          32'd0,          32);
    run_op("divu_max_1",   2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32);
    run_op("divu_3_5",     2'b10, 32'd3,          32'd5,          32'd0,          32);
    run_op("remu_3_5",     2'b11, 32'd3,          32'd5,          32'd3,          32);
    run_op("divu_5_0",     2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  ZLAT);
    run_op("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5,          ZLAT);
    run_op("mul_0x5",      2'b00, 32'd0,          32'd5,          32'd0,          ZLAT);
    run_op("mulhu_9x0",    2'b01, 32'd9,          32'd0,          32'd0,          ZLAT);

    // start held high with new operands while running must be ignored
    bus.i_start = 1'b1; bus.i_ctrl = 2'b00; bus.i_1 = 32'd7; bus.i_2 = 32'd6;
    @(posedge clk); #1;
    bus.i_ctrl = 2'b10; bus.i_1 = 32'd9; bus.i_2 = 32'd3;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      if (k == 20) bus.i_start = 1'b0;
      @(posedge clk); #1;
      if (bus.o_done) seen = 1'b1;
    end
    chk("ign_done_seen", 32'(seen), 32'd1);
    chk("ign_result", bus.o_1, 32'd42);
    @(posedge clk); #1;

    // reset mid-RUN aborts with no done pulse and clears outputs at once
    bus.i_start = 1'b1; bus.i_ctrl = 2'b10; bus.i_1 = 32'd100; bus.i_2 = 32'd7;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    chk("abort_o1", bus.o_1, 32'd0);
    chk("abort_zero", 32'(bus.o_zero), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle", 32'(bus.o_busy), 32'd0);
    run_op("post_rst_mul", 2'b00, 32'd1234, 32'd1000, 32'd1234000, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
